branch_update_ctrl: RTL
=======================

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight predicted branches tracked (power of two, 2..8).
REQ-002 SHALL have parameter IDX_W, default 6, meaning the predictor table index width (64 entries).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fetch_idx  input  IDX_W  PC-derived index bits of the branch currently in fetch.
REQ-006 pred_valid  input  1  fetch made a prediction this cycle (enqueue request).
REQ-007 pred_taken  input  1  predicted direction returned by the table for that branch.
REQ-008 pred_ready  output  1  queue can accept an enqueue (count < DEPTH).
REQ-009 res_valid  input  1  execute resolved the oldest in-flight branch.
REQ-010 res_taken  input  1  actual direction of that branch.
REQ-011 flush  input  1  squash all in-flight branches (pipeline redirect from a non-branch source).
REQ-012 PredictorIndex  output  IDX_W  index driven to the counter table.
REQ-013 change  output  2  table command: 2'b11 increment (taken), 2'b10 decrement (not taken), 2'b00 lookup.
REQ-014 lookup_stall  output  1  table port busy with an update; fetch must not use the prediction this cycle.
REQ-015 mispredict  output  1  one-cycle pulse, resolved direction differed from the queued prediction.
REQ-016 inflight  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-017 SHALL hold a speculative history spec_ghr[IDX_W-1:0] and a committed history arch_ghr[IDX_W-1:0].
REQ-018 Lookup index SHALL be fetch_idx XOR spec_ghr; it is combinational and drives PredictorIndex whenever no update is issuing.
REQ-019 On enqueue (pred_valid && pred_ready && !flush && !mispredict-recovery in that cycle), the queue SHALL store {lookup index, pred_taken} at the tail and set spec_ghr <= {spec_ghr[IDX_W-2:0], pred_taken}.
REQ-020 pred_valid while pred_ready is 0 SHALL be dropped, with no state change.
REQ-021 On res_valid with inflight > 0, the queue SHALL pop the head and set arch_ghr <= {arch_ghr[IDX_W-2:0], res_taken}.
REQ-022 res_valid with inflight == 0 SHALL be ignored: no update, no pulse, no history change.
REQ-023 The update SHALL be registered: a resolution at edge N drives PredictorIndex = popped index and change = {1'b1, res_taken} for exactly the cycle after edge N, with lookup_stall = 1 in that cycle.
REQ-024 FSM states: IDLE (change = 00, lookup_stall = 0) and UPDATE (one cycle only). Transitions: IDLE->UPDATE on a valid resolution; UPDATE->UPDATE on a back-to-back resolution; otherwise UPDATE->IDLE.
REQ-025 If res_taken != the popped pred_taken, mispredict SHALL pulse in the same cycle as the update. At that edge, all younger entries SHALL be discarded (inflight <= 0), spec_ghr SHALL be set to {arch_ghr[IDX_W-2:0], res_taken}, and any same-edge enqueue SHALL be dropped.
REQ-026 Simultaneous enqueue and correct resolution SHALL leave inflight unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-027 When full, pred_ready SHALL be 0 even if a resolution occurs in the same cycle (no bypass).
REQ-028 flush with res_valid in the same cycle: the resolution SHALL be processed first (pop, arch_ghr update, registered update and mispredict check). The queue is then cleared, and spec_ghr <= the new arch_ghr value.
REQ-029 flush without res_valid SHALL clear the queue and set spec_ghr <= arch_ghr. A same-cycle enqueue SHALL be dropped.

Reset
REQ-030 While reset = 0, the block SHALL immediately force: queue empty (inflight = 0), pointers 0, spec_ghr = arch_ghr = 0, FSM IDLE, change = 00, mispredict = 0, lookup_stall = 0, and pred_ready = 1.
REQ-031 An in-flight update interrupted by reset SHALL be abandoned, and change SHALL be 00 from reset assertion onward.
REQ-032 The first enqueue SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 Enqueue: fetch_idx = 6'h05 with pred_taken = 1 -> entry index 6'h05, spec_ghr = 6'h01. The next fetch_idx = 6'h05 yields PredictorIndex = 6'h04.
REQ-034 Correct resolution: res_valid = 1, res_taken = 1 -> the next cycle shows PredictorIndex = 6'h05, change = 11, lookup_stall = 1, mispredict = 0, and arch_ghr = 6'h01.
REQ-035 Mispredict: 3 entries queued, oldest predicted 1, res_taken = 0 -> change = 10 and mispredict = 1 for one cycle, inflight = 0, spec_ghr = {arch_ghr[4:0], 0}.
REQ-036 Full queue: 4 enqueues -> pred_ready = 0. A 5th pred_valid is dropped, and a resolve plus enqueue in the same cycle accepts no enqueue (inflight = 3).
REQ-037 Empty resolve and wrap: res_valid with inflight = 0 -> change stays 00. Ten enqueue/resolve pairs -> FIFO order is preserved across pointer wrap.
REQ-038 Flush with resolution plus async reset: flush and res_valid in the same cycle -> one update is issued, then inflight = 0 and spec_ghr = arch_ghr. Asserting reset during UPDATE -> change = 00 immediately.

Source files
------------

// File: rtl/branch_update_ctrl.sv
// Branch predictor update controller: tracks in-flight predictions in a FIFO and issues
// registered increment/decrement commands to the counter table, with speculative/committed history.
module branch_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IDX_W-1:0]         fetch_idx,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic                     flush,
    output logic [IDX_W-1:0]         PredictorIndex,
    output logic [1:0]               change,
    output logic                     lookup_stall,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   inflight
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      head_q, tail_q;
    logic [IDX_W-1:0]   spec_ghr, arch_ghr, arch_next;
    logic [IDX_W-1:0]   q_idx [DEPTH];
    logic               q_pred [DEPTH];
    logic [IDX_W-1:0]   upd_idx;
    logic               upd_taken;
    logic               mispred_q;
    logic [IDX_W-1:0]   lookup_idx;
    logic               do_res, recover, do_enq, clear;

    assign lookup_idx = fetch_idx ^ spec_ghr;
    assign pred_ready = (count_q < CW'(DEPTH));
    assign do_res     = res_valid && (count_q != '0);
    assign recover    = do_res && (res_taken != q_pred[head_q]);
    assign do_enq     = pred_valid && pred_ready && !flush && !recover;
    assign clear      = flush || recover;
    assign arch_next  = do_res ? {arch_ghr[IDX_W-2:0], res_taken} : arch_ghr;
    assign inflight   = count_q;
    assign mispredict = mispred_q;

    always_comb begin
        count_d = count_q + CW'(do_enq) - CW'(do_res);
        if (clear) count_d = '0;
    end

    always_comb begin
        state_d        = do_res ? UPDATE : IDLE;
        change         = 2'b00;
        lookup_stall   = 1'b0;
        PredictorIndex = lookup_idx;
        if (state_q == UPDATE) begin
            change         = {1'b1, upd_taken};
            lookup_stall   = 1'b1;
            PredictorIndex = upd_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            spec_ghr  <= '0;
            arch_ghr  <= '0;
            upd_idx   <= '0;
            upd_taken <= 1'b0;
            mispred_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            arch_ghr  <= arch_next;
            mispred_q <= recover;
            if (do_res) begin
                upd_idx   <= q_idx[head_q];
                upd_taken <= res_taken;
            end
            // Recovery/flush rebuilds speculative history from the post-resolution committed history
            if (clear) begin
                head_q   <= '0;
                tail_q   <= '0;
                spec_ghr <= arch_next;
            end else begin
                if (do_res) head_q <= head_q + PW'(1);
                if (do_enq) begin
                    tail_q   <= tail_q + PW'(1);
                    spec_ghr <= {spec_ghr[IDX_W-2:0], pred_taken};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            q_idx[tail_q]  <= lookup_idx;
            q_pred[tail_q] <= pred_taken;
        end
    end
endmodule
